hamming_decoder_pipe: RTL and testbench
=======================================

// Module: hamming_decoder_pipe
// PURPOSE
//   Streaming Hamming(7,4) decoder placed directly downstream of hamming_encoder (after the channel).
//   Accepts one 7-bit codeword per valid/ready handshake and computes the 3-bit syndrome.
//   Corrects any single-bit error and returns the 4 data bits with error status.
//   Keeps a saturating count of corrected words for link-health monitoring.
// PARAMETERS
//   CNT_W       16  width of the corrected-error counter err_cnt
//   CORRECT_EN  1   1: flip the erroneous bit; 0: detect/flag only, data passed uncorrected
// PORTS
//   clk         in   1      single clock, all state on rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   in_valid    in   1      in_code holds a codeword
//   in_ready    out  1      block can accept in_code this cycle
//   in_code     in   7      codeword, bit map [0]=p1 [1]=p2 [2]=d0 [3]=p4 [4]=d1 [5]=d2 [6]=d3
//   out_valid   out  1      out_* fields hold a decoded word
//   out_ready   in   1      consumer accepts the word this cycle
//   out_data    out  4      decoded data {d3,d2,d1,d0}
//   out_err     out  1      syndrome was non-zero for this word
//   out_syn     out  3      syndrome {s4,s2,s1}; non-zero value = 1-based bit position in error
//   cnt_clr     in   1      synchronous clear of err_cnt
//   err_cnt     out  CNT_W  number of out_err words handed off, saturating
// BEHAVIOUR
//   Reset (async assert, sync release): both stage valids=0, out_data/out_err/out_syn=0, err_cnt=0.
//   Syndrome terms:
//     s1 = c0^c2^c4^c6
//     s2 = c1^c2^c5^c6
//     s4 = c3^c4^c5^c6
//   Correction: if syn!=0 and CORRECT_EN, invert c[syn-1]; out_data = {c6,c5,c4,c2} of the result.
//   Pipeline: 2 register stages.
//     S1 registers the code and syndrome.
//     S2 registers the corrected data, out_err and out_syn; S2 drives out_*.
//   Latency: a word accepted in cycle N is out_valid at N+2 when there is no backpressure.
//   Stage enables:
//     s2_en = !s2_valid | out_ready
//     s1_en = !s1_valid | s2_en
//     in_ready = s1_en (combinational from out_ready)
//   Throughput: 1 word/cycle sustained while out_ready=1.
//   Stalls: under backpressure both stages hold contents; no word is lost or duplicated.
//   A bubble in S1 is absorbed when S2 stalls, so at most 2 words are in flight.
//   out_* are stable while out_valid=1 and out_ready=0; when out_valid=0 they hold their last values.
//   err_cnt:
//     +1 on the cycle out_valid & out_ready & out_err.
//     Saturates at 2**CNT_W-1, no wrap.
//     cnt_clr has priority over a same-cycle increment (result 0).
//   Double-bit errors are not detectable by this code: they are miscorrected and flagged as single, by design.
//   Reset mid-stream: in-flight words are discarded and out_valid drops asynchronously; err_cnt = 0.
// STRUCTURE
//   hamming_pkg, shared with hamming_encoder:
//     code_t (logic [6:0]), data_t (logic [3:0]), syn_t (logic [2:0])
//     function calc_syndrome(code_t)
//     function extract_data(code_t)
//   Sub-module hamming_syndrome: combinational code_t -> syn_t, reusable by the encoder bench checker.
//   Datapath and handshake logic stay in this module.
// TESTING
//   Clean word: in_code=7'h55, out_ready=1 -> 2 cycles later out_data=4'hB, out_err=0, out_syn=0.
//   Single error: 7'h45 (bit4 flipped) -> out_data=4'hB, out_err=1, out_syn=3'd5, err_cnt=1.
//   Exhaustive: all 16 data x 8 patterns (none + each single flip) back-to-back -> all data recovered,
//     err_cnt=112, no bubbles.
//   Backpressure: out_ready=0 for 5 cycles while streaming -> in_ready=0 after 2 words,
//     out_* stable, order preserved after release.
//   Counter: CNT_W=2, send 5 erred words -> err_cnt=3 (saturated);
//     cnt_clr with a coincident erred handoff -> err_cnt=0.
//   Reset mid-stream with 2 words in flight -> out_valid=0 immediately;
//     after release in_ready=1 and err_cnt=0.
//   CORRECT_EN=0: 7'h01 -> out_data=4'h0 (bit 0 is parity), out_syn=1;
//     7'h04 -> out_data=4'h1, out_syn=3, out_err=1.

Source files
------------

// File: rtl/hamming_pkg.sv
package hamming_pkg;

  typedef logic [6:0] code_t;
  typedef logic [3:0] data_t;
  typedef logic [2:0] syn_t;

  function automatic syn_t calc_syndrome(input code_t c);
    return {c[3] ^ c[4] ^ c[5] ^ c[6],
            c[1] ^ c[2] ^ c[5] ^ c[6],
            c[0] ^ c[2] ^ c[4] ^ c[6]};
  endfunction

  function automatic data_t extract_data(input code_t c);
    return {c[6], c[5], c[4], c[2]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [6:0] code,
  output logic [2:0] syn
);

  // Stage 0: combinational syndrome of one codeword
  assign syn = calc_syndrome(code);

endmodule

// File: rtl/hamming_decoder_pipe.sv
module hamming_decoder_pipe
  import hamming_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter bit CORRECT_EN = 1'b1
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_err,
  output logic [2:0]       out_syn,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_cnt
);

  function automatic code_t correct_code(input code_t code, input syn_t syn);
    code_t flip;
    flip = '0;
    if (CORRECT_EN && (syn != 3'd0)) flip[syn - 3'd1] = 1'b1;
    return code ^ flip;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  syn_t             syn_p0;
  code_t            code_p1;
  syn_t             syn_p1;
  logic             vld_p1;
  data_t            data_p2;
  logic             err_p2;
  syn_t             syn_p2;
  logic             vld_p2;
  logic [CNT_W-1:0] cnt;
  logic             s1_en;
  logic             s2_en;
  code_t            fixed_p1;

  assign s2_en    = !vld_p2 || out_ready;
  assign s1_en    = !vld_p1 || s2_en;
  assign in_ready = s1_en;

  // Stage 0: syndrome of the incoming codeword
  hamming_syndrome u_syn (
    .code (in_code),
    .syn  (syn_p0)
  );

  // Stage 1: register code and syndrome
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      code_p1 <= '0;
      syn_p1  <= '0;
    end else if (s1_en) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        code_p1 <= in_code;
        syn_p1  <= syn_p0;
      end
    end
  end

  assign fixed_p1 = correct_code(code_p1, syn_p1);

  // Stage 2: register corrected data and status, drives out_*
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      err_p2  <= 1'b0;
      syn_p2  <= '0;
    end else if (s2_en) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= extract_data(fixed_p1);
        err_p2  <= (syn_p1 != 3'd0);
        syn_p2  <= syn_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_err   = err_p2;
  assign out_syn   = syn_p2;

  // Output handoff: saturating count of erred words, clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (vld_p2 && out_ready && err_p2) begin
      cnt <= sat_inc(cnt);
    end
  end

  assign err_cnt = cnt;

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
module tb_hamming_decoder_pipe;

  typedef struct {
    logic [6:0] code;
    logic [3:0] data;
    logic       err;
    logic [2:0] syn;
    logic [3:0] nc_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [6:0]  in_code;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready, out_valid, out_err;
  logic [3:0]  out_data;
  logic [2:0]  out_syn;
  logic [15:0] err_cnt;

  logic        sat_in_ready, sat_out_valid, sat_out_err;
  logic [3:0]  sat_out_data;
  logic [2:0]  sat_out_syn;
  logic [1:0]  sat_err_cnt;

  logic        nc_in_ready, nc_out_valid, nc_out_err;
  logic [3:0]  nc_out_data;
  logic [2:0]  nc_out_syn;
  logic [15:0] nc_err_cnt;

  int checks = 0;
  int errors = 0;

  vec_t send_q[$];
  vec_t exp_q[$];
  int   got;
  logic s_in_ready, s_out_valid;
  logic [3:0] s_out_data;

  always #5 clk = ~clk;

  hamming_decoder_pipe #(.CNT_W(16), .CORRECT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .out_syn(out_syn), .cnt_clr(cnt_clr), .err_cnt(err_cnt));

  hamming_decoder_pipe #(.CNT_W(2), .CORRECT_EN(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready), .in_code(in_code),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data), .out_err(sat_out_err),
    .out_syn(sat_out_syn), .cnt_clr(cnt_clr), .err_cnt(sat_err_cnt));

  hamming_decoder_pipe #(.CNT_W(16), .CORRECT_EN(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nc_in_ready), .in_code(in_code),
    .out_valid(nc_out_valid), .out_ready(out_ready), .out_data(nc_out_data), .out_err(nc_out_err),
    .out_syn(nc_out_syn), .cnt_clr(cnt_clr), .err_cnt(nc_err_cnt));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

  // One clock of streaming: present head of send_q, score any handoff, advance.
  task automatic tick();
    vec_t e;
    in_valid = (send_q.size() > 0);
    in_code  = (send_q.size() > 0) ? send_q[0].code : 7'h00;
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("stream_data", out_data, e.data);
        chk("stream_err", out_err, e.err);
        chk("stream_syn", out_syn, e.syn);
        chk("stream_nc_data", nc_out_data, e.nc_data);
      end
      got++;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(send_q[0]);
      void'(send_q.pop_front());
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[12];
    vec_t v;
    int   n_err;
    int   t;

    tbl[0]  = '{7'h55, 4'hB, 1'b0, 3'd0, 4'hB};
    tbl[1]  = '{7'h45, 4'hB, 1'b1, 3'd5, 4'h9};
    tbl[2]  = '{7'h01, 4'h0, 1'b1, 3'd1, 4'h0};
    tbl[3]  = '{7'h04, 4'h0, 1'b1, 3'd3, 4'h1};
    tbl[4]  = '{7'h73, 4'h6, 1'b1, 3'd7, 4'hE};
    tbl[5]  = '{7'h54, 4'hB, 1'b1, 3'd1, 4'hB};
    tbl[6]  = '{7'h51, 4'hB, 1'b1, 3'd3, 4'hA};
    tbl[7]  = '{7'h7F, 4'hF, 1'b0, 3'd0, 4'hF};
    tbl[8]  = '{7'h77, 4'hF, 1'b1, 3'd4, 4'hF};
    tbl[9]  = '{7'h20, 4'h0, 1'b1, 3'd6, 4'h4};
    tbl[10] = '{7'h33, 4'h6, 1'b0, 3'd0, 4'h6};
    tbl[11] = '{7'h00, 4'h0, 1'b0, 3'd0, 4'h0};

    rst_n = 1'b0; in_valid = 1'b0; in_code = 7'h00; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 4'h0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_out_syn", out_syn, 3'd0);
    chk("rst_err_cnt", err_cnt, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Directed table, one word at a time
    n_err = 0;
    for (int i = 0; i < 12; i++) begin
      v = tbl[i];
      in_valid = 1'b1; in_code = v.code; out_ready = 1'b1;
      #1;
      chk("tbl_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("tbl_latency_early", out_valid, 1'b0);
      @(posedge clk); #1;
      chk("tbl_out_valid", out_valid, 1'b1);
      chk("tbl_data", out_data, v.data);
      chk("tbl_err", out_err, v.err);
      chk("tbl_syn", out_syn, v.syn);
      chk("tbl_nc_data", nc_out_data, v.nc_data);
      chk("tbl_nc_syn", nc_out_syn, v.syn);
      if (v.err) n_err++;
      @(posedge clk); #1;
      chk("tbl_drop_valid", out_valid, 1'b0);
      chk("tbl_hold_data", out_data, v.data);
      chk("tbl_err_cnt", err_cnt, n_err);
      chk("tbl_sat_cnt", sat_err_cnt, (n_err > 3) ? 3 : n_err);
    end

    // Exhaustive back-to-back stream
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_err_cnt", err_cnt, 16'd0);
    for (int d = 0; d < 16; d++) begin
      for (int k = 0; k < 8; k++) begin
        v.code = encode(d[3:0]);
        v.data = d[3:0];
        v.err  = (k != 0);
        v.syn  = k[2:0];
        if (k != 0) v.code[k-1] = ~v.code[k-1];
        v.nc_data = {v.code[6], v.code[5], v.code[4], v.code[2]};
        send_q.push_back(v);
      end
    end
    got = 0; t = 0; out_ready = 1'b1;
    while (got < 128 && t < 200) begin
      tick();
      t++;
      if (send_q.size() > 0 && !s_in_ready) chk("exh_in_ready", s_in_ready, 1'b1);
    end
    chk("exh_words", got, 128);
    chk("exh_cycles_no_bubble", t, 130);
    chk("exh_err_cnt", err_cnt, 16'd112);
    chk("exh_sat_cnt", sat_err_cnt, 2'd3);
    chk("exh_nc_cnt", nc_err_cnt, 16'd112);

    // Backpressure: 5 stalled cycles while streaming
    for (int d = 1; d <= 6; d++) begin
      v.code = encode(d[3:0]); v.data = d[3:0]; v.err = 1'b0; v.syn = 3'd0; v.nc_data = d[3:0];
      send_q.push_back(v);
    end
    got = 0; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_in_ready", s_in_ready, (c < 2) ? 1'b1 : 1'b0);
      if (c >= 2) begin
        chk("bp_out_valid", s_out_valid, 1'b1);
        chk("bp_out_stable", s_out_data, 4'h1);
      end
    end
    out_ready = 1'b1; t = 0;
    while (got < 6 && t < 30) begin
      tick();
      t++;
    end
    chk("bp_words", got, 6);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Counter clear coincident with an erred handoff
    send_q.push_back(tbl[1]);
    out_ready = 1'b0; t = 0;
    s_out_valid = 1'b0;
    while (!s_out_valid && t < 10) begin
      tick();
      t++;
    end
    chk("clr_word_ready", s_out_valid, 1'b1);
    out_ready = 1'b1; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_prio_cnt", err_cnt, 16'd0);
    chk("clr_prio_sat", sat_err_cnt, 2'd0);

    // Reset with two words in flight
    got = 0;
    for (int i = 0; i < 3; i++) send_q.push_back(tbl[1]);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    #1;
    chk("pre_rst_cnt", err_cnt, 16'd1);
    chk("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_sat_valid", sat_out_valid, 1'b0);
    chk("mid_rst_err_cnt", err_cnt, 16'd0);
    chk("mid_rst_out_syn", out_syn, 3'd0);
    send_q.delete();
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_in_ready", in_ready, 1'b1);
    chk("after_rst_out_valid", out_valid, 1'b0);
    chk("after_rst_err_cnt", err_cnt, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
